// File: rtl/uart_reg_bank_pkg.sv
// Shared register-map definitions for the UART register bank: bus widths,
// register indices, field bit positions and reset values.
package uart_reg_bank_pkg;

   localparam int unsigned UART_NUMB_REG_WD = 3;
   localparam int unsigned UART_DATA_REG_WD = 32;

   typedef enum logic [UART_NUMB_REG_WD-1:0] {
      UART_REG_CTRL  = 3'd0,
      UART_REG_BAUD  = 3'd1,
      UART_REG_STAT  = 3'd2,
      UART_REG_TXDAT = 3'd3,
      UART_REG_RXDAT = 3'd4,
      UART_REG_ISR   = 3'd5
   } uart_reg_e;

   localparam int unsigned CTRL_TX_EN  = 0;
   localparam int unsigned CTRL_RX_EN  = 1;
   localparam int unsigned CTRL_IE_LSB = 4;
   localparam logic [6:0]  CTRL_MASK   = 7'b111_0011;

   localparam int unsigned STAT_TX_FULL  = 0;
   localparam int unsigned STAT_TX_EMPTY = 1;
   localparam int unsigned STAT_RX_FULL  = 2;
   localparam int unsigned STAT_TX_OVF   = 3;
   localparam int unsigned STAT_RX_OVF   = 4;
   localparam int unsigned STAT_CNT_LSB  = 8;

   localparam int unsigned ISR_TXE = 0;
   localparam int unsigned ISR_RXV = 1;
   localparam int unsigned ISR_OVF = 2;

   localparam int unsigned UART_BAUD_RST = 434;

endpackage

// File: rtl/uart_fifo_sync.sv
// Synchronous FIFO with registered storage; head data is read combinationally.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module uart_fifo_sync #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      cnt_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign cnt_o   = cnt_q;
   assign dat_o   = mem_q[rd_ptr_q];

   always_comb begin
      pop_ok   = pop_i && !empty_o;
      push_ok  = push_i && (!full_o || pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = dat_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_reg_bank.sv
// UART register bank: control/baud config, TX FIFO, RX holding register,
// sticky status, W1C interrupt pending bits and registered read data.
module uart_reg_bank
   import uart_reg_bank_pkg::*;
#(
   parameter int unsigned TX_FIFO_DEPTH = 4,
   parameter int unsigned TX_FIFO_AW    = 2,
   parameter int unsigned BAUD_WD       = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [UART_NUMB_REG_WD-1:0] reg_adr_i,
   input  logic                        reg_wr_val_i,
   input  logic [UART_DATA_REG_WD-1:0] reg_wr_dat_i,
   input  logic                        reg_rd_val_i,
   output logic [UART_DATA_REG_WD-1:0] reg_rd_dat_o,
   output logic                        cfg_tx_en_o,
   output logic                        cfg_rx_en_o,
   output logic [BAUD_WD-1:0]          cfg_baud_o,
   output logic                        tx_val_o,
   output logic [7:0]                  tx_dat_o,
   input  logic                        tx_rdy_i,
   input  logic                        rx_val_i,
   input  logic [7:0]                  rx_dat_i,
   output logic                        irq_o
);

   logic [6:0]                  ctrl_q, ctrl_d;
   logic [BAUD_WD-1:0]          baud_q, baud_d;
   logic                        tx_ovf_q, tx_ovf_d;
   logic                        rx_ovf_q, rx_ovf_d;
   logic                        rx_full_q, rx_full_d;
   logic [7:0]                  rx_byte_q, rx_byte_d;
   logic [2:0]                  isr_q, isr_d;
   logic                        irq_q, irq_d;
   logic [UART_DATA_REG_WD-1:0] rd_dat_q, rd_dat_d;

   logic                        tx_full, tx_empty, tx_push, tx_pop, tx_drop, txe_set;
   logic [TX_FIFO_AW:0]         tx_cnt;
   logic                        rd_en, rx_pop, rx_hit, rx_load, rx_drop;
   logic [UART_DATA_REG_WD-1:0] rd_mux;
   logic                        unused_wr_dat;

   assign unused_wr_dat = ^reg_wr_dat_i;

   uart_fifo_sync #(
      .WIDTH (8),
      .DEPTH (TX_FIFO_DEPTH),
      .AW    (TX_FIFO_AW)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_push),
      .dat_i   (reg_wr_dat_i[7:0]),
      .pop_i   (tx_pop),
      .dat_o   (tx_dat_o),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .cnt_o   (tx_cnt)
   );

   always_comb begin
      // A write strobe always wins over a coincident read strobe.
      rd_en   = reg_rd_val_i && !reg_wr_val_i;
      tx_push = reg_wr_val_i && (reg_adr_i == UART_REG_TXDAT);
      tx_pop  = !tx_empty && tx_rdy_i;
      tx_drop = tx_push && tx_full && !tx_pop;
      txe_set = tx_pop && !tx_push && (tx_cnt == (TX_FIFO_AW+1)'(1));
      rx_pop  = rd_en && (reg_adr_i == UART_REG_RXDAT) && rx_full_q;
      rx_hit  = rx_val_i && ctrl_q[CTRL_RX_EN];
      rx_load = rx_hit && (!rx_full_q || rx_pop);
      rx_drop = rx_hit && rx_full_q && !rx_pop;

      rd_mux = '0;
      case (reg_adr_i)
         UART_REG_CTRL: rd_mux = UART_DATA_REG_WD'(ctrl_q);
         UART_REG_BAUD: rd_mux = UART_DATA_REG_WD'(baud_q);
         UART_REG_STAT: begin
            rd_mux[STAT_TX_FULL]  = tx_full;
            rd_mux[STAT_TX_EMPTY] = tx_empty;
            rd_mux[STAT_RX_FULL]  = rx_full_q;
            rd_mux[STAT_TX_OVF]   = tx_ovf_q;
            rd_mux[STAT_RX_OVF]   = rx_ovf_q;
            rd_mux[STAT_CNT_LSB +: TX_FIFO_AW+1] = tx_cnt;
         end
         UART_REG_RXDAT: rd_mux = UART_DATA_REG_WD'(rx_byte_q);
         UART_REG_ISR:   rd_mux = UART_DATA_REG_WD'(isr_q);
         default:        rd_mux = '0;
      endcase

      ctrl_d    = ctrl_q;
      baud_d    = baud_q;
      tx_ovf_d  = tx_ovf_q;
      rx_ovf_d  = rx_ovf_q;
      isr_d     = isr_q;
      rx_full_d = rx_full_q;
      rx_byte_d = rx_byte_q;
      rd_dat_d  = rd_en ? rd_mux : rd_dat_q;

      if (reg_wr_val_i) begin
         case (reg_adr_i)
            UART_REG_CTRL: ctrl_d = reg_wr_dat_i[6:0] & CTRL_MASK;
            UART_REG_BAUD: baud_d = reg_wr_dat_i[BAUD_WD-1:0];
            UART_REG_STAT: begin
               tx_ovf_d = tx_ovf_q && !reg_wr_dat_i[STAT_TX_OVF];
               rx_ovf_d = rx_ovf_q && !reg_wr_dat_i[STAT_RX_OVF];
            end
            UART_REG_ISR:  isr_d = isr_q & ~reg_wr_dat_i[2:0];
            default: ;
         endcase
      end

      // Sets are applied after the clears so that set wins.
      if (tx_drop) tx_ovf_d = 1'b1;
      if (rx_drop) rx_ovf_d = 1'b1;
      if (txe_set) isr_d[ISR_TXE] = 1'b1;
      if (rx_load) isr_d[ISR_RXV] = 1'b1;
      if (tx_drop || rx_drop) isr_d[ISR_OVF] = 1'b1;

      if (rx_load) begin
         rx_full_d = 1'b1;
         rx_byte_d = rx_dat_i;
      end else if (rx_pop) begin
         rx_full_d = 1'b0;
      end

      irq_d = |(isr_q & ctrl_q[CTRL_IE_LSB +: 3]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q    <= '0;
         baud_q    <= BAUD_WD'(UART_BAUD_RST);
         tx_ovf_q  <= 1'b0;
         rx_ovf_q  <= 1'b0;
         rx_full_q <= 1'b0;
         rx_byte_q <= '0;
         isr_q     <= '0;
         irq_q     <= 1'b0;
         rd_dat_q  <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         baud_q    <= baud_d;
         tx_ovf_q  <= tx_ovf_d;
         rx_ovf_q  <= rx_ovf_d;
         rx_full_q <= rx_full_d;
         rx_byte_q <= rx_byte_d;
         isr_q     <= isr_d;
         irq_q     <= irq_d;
         rd_dat_q  <= rd_dat_d;
      end
   end

   assign reg_rd_dat_o = rd_dat_q;
   assign cfg_tx_en_o  = ctrl_q[CTRL_TX_EN];
   assign cfg_rx_en_o  = ctrl_q[CTRL_RX_EN];
   assign cfg_baud_o   = baud_q;
   assign tx_val_o     = !tx_empty;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Self-checking bench for uart_reg_bank: a vector table for register access
// plus directed sequences, with read and TX byte scoreboards.
module tb_uart_reg_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  reg_adr_i;
   logic        reg_wr_val_i;
   logic [31:0] reg_wr_dat_i;
   logic        reg_rd_val_i;
   logic [31:0] reg_rd_dat_o;
   logic        cfg_tx_en_o, cfg_rx_en_o;
   logic [15:0] cfg_baud_o;
   logic        tx_val_o;
   logic [7:0]  tx_dat_o;
   logic        tx_rdy_i;
   logic        rx_val_i;
   logic [7:0]  rx_dat_i;
   logic        irq_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          is_wr;
      logic [2:0]  adr;
      logic [31:0] dat;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] exp;
      string       nm;
   } rd_exp_t;

   vec_t      vecs[15];
   rd_exp_t   rdq[$];
   logic [7:0] txq[$];

   uart_reg_bank #(
      .TX_FIFO_DEPTH (4),
      .TX_FIFO_AW    (2),
      .BAUD_WD       (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .reg_adr_i    (reg_adr_i),
      .reg_wr_val_i (reg_wr_val_i),
      .reg_wr_dat_i (reg_wr_dat_i),
      .reg_rd_val_i (reg_rd_val_i),
      .reg_rd_dat_o (reg_rd_dat_o),
      .cfg_tx_en_o  (cfg_tx_en_o),
      .cfg_rx_en_o  (cfg_rx_en_o),
      .cfg_baud_o   (cfg_baud_o),
      .tx_val_o     (tx_val_o),
      .tx_dat_o     (tx_dat_o),
      .tx_rdy_i     (tx_rdy_i),
      .rx_val_i     (rx_val_i),
      .rx_dat_i     (rx_dat_i),
      .irq_o        (irq_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
      // TX model: a TXDAT write is accepted if there is room (pops are applied first by caller)
      if (adr == 3'd3 && txq.size() < 4) txq.push_back(dat[7:0]);
      reg_adr_i    = adr;
      reg_wr_dat_i = dat;
      reg_wr_val_i = 1'b1;
      tick();
      reg_wr_val_i = 1'b0;
   endtask

   task automatic rd(input logic [2:0] adr, input logic [31:0] exp, input string nm);
      rd_exp_t e;
      e.exp = exp;
      e.nm  = nm;
      rdq.push_back(e);
      reg_adr_i    = adr;
      reg_rd_val_i = 1'b1;
      tick();
      reg_rd_val_i = 1'b0;
      e = rdq.pop_front();
      chk(e.nm, reg_rd_dat_o, e.exp);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 3'd0, 32'h0,    32'h0};
      vecs[1]  = '{1'b0, 3'd1, 32'h0,    32'h1B2};
      vecs[2]  = '{1'b0, 3'd2, 32'h0,    32'h2};
      vecs[3]  = '{1'b0, 3'd3, 32'h0,    32'h0};
      vecs[4]  = '{1'b0, 3'd4, 32'h0,    32'h0};
      vecs[5]  = '{1'b0, 3'd5, 32'h0,    32'h0};
      vecs[6]  = '{1'b0, 3'd6, 32'h0,    32'h0};
      vecs[7]  = '{1'b0, 3'd7, 32'h0,    32'h0};
      vecs[8]  = '{1'b1, 3'd1, 32'h36,   32'h0};
      vecs[9]  = '{1'b1, 3'd0, 32'h03,   32'h0};
      vecs[10] = '{1'b1, 3'd6, 32'hFFFF, 32'h0};
      vecs[11] = '{1'b0, 3'd6, 32'h0,    32'h0};
      vecs[12] = '{1'b0, 3'd1, 32'h0,    32'h36};
      vecs[13] = '{1'b0, 3'd0, 32'h0,    32'h03};
      vecs[14] = '{1'b0, 3'd2, 32'h0,    32'h2};

      rst = 1'b1;
      reg_adr_i = '0; reg_wr_val_i = 0; reg_wr_dat_i = '0; reg_rd_val_i = 0;
      tx_rdy_i = 0; rx_val_i = 0; rx_dat_i = '0;
      tick(); tick();
      chk("rst_tx_val", 32'(tx_val_o), 0);
      chk("rst_tx_dat", 32'(tx_dat_o), 0);
      chk("rst_irq", 32'(irq_o), 0);
      chk("rst_rd_dat", reg_rd_dat_o, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 15; i++) begin
         if (vecs[i].is_wr) wr(vecs[i].adr, vecs[i].dat);
         else rd(vecs[i].adr, vecs[i].exp, $sformatf("vec%0d_rd%0d", i, vecs[i].adr));
      end
      tick(); tick();
      chk("rd_hold", reg_rd_dat_o, 32'h2);
      chk("cfg_baud", 32'(cfg_baud_o), 32'h36);
      chk("cfg_en", {30'b0, cfg_rx_en_o, cfg_tx_en_o}, 32'h3);

      // TX fill, overflow, clear, full push+pop, drain
      wr(3'd0, 32'h13);
      for (int b = 0; b < 5; b++) begin
         if (b == 4) rd(3'd2, 32'h401, "stat_full");
         wr(3'd3, 32'h41 + b);
      end
      rd(3'd2, 32'h409, "stat_tx_ovf");
      chk("irq_ovf_masked", 32'(irq_o), 0);
      wr(3'd2, 32'h08);
      rd(3'd2, 32'h401, "stat_ovf_clr");
      chk("tx_head", 32'(tx_dat_o), 32'h41);
      tx_rdy_i = 1'b1;
      void'(txq.pop_front());
      wr(3'd3, 32'h46);
      tx_rdy_i = 1'b0;
      rd(3'd2, 32'h401, "stat_full_pushpop");
      tx_rdy_i = 1'b1;
      for (int n = 0; n < 20; n++) begin
         if (!tx_val_o) break;
         if (txq.size() == 0) chk("tx_extra", 32'(tx_dat_o), 32'hFFFF_FFFF);
         else chk($sformatf("tx_byte%0d", n), 32'(tx_dat_o), 32'(txq.pop_front()));
         tick();
      end
      tx_rdy_i = 1'b0;
      chk("tx_drained", {31'b0, tx_val_o}, 0);
      chk("tx_left", txq.size(), 0);
      chk("irq_txe_lat", 32'(irq_o), 0);
      tick();
      chk("irq_txe", 32'(irq_o), 1);
      rd(3'd5, 32'h5, "isr_txe_ovf");
      wr(3'd5, 32'h7);
      tick();
      chk("irq_cleared", 32'(irq_o), 0);
      rd(3'd5, 32'h0, "isr_clr");

      // RX holding register
      rx_val_i = 1'b1; rx_dat_i = 8'h5A; tick();
      rx_dat_i = 8'hA5; tick();
      rx_val_i = 1'b0;
      rd(3'd2, 32'h16, "stat_rx_ovf");
      rd(3'd4, 32'h5A, "rx_keep_old");
      wr(3'd2, 32'h10);
      rd(3'd2, 32'h02, "stat_rx_ovf_clr");
      rx_val_i = 1'b1; rx_dat_i = 8'h77; tick();
      rx_dat_i = 8'h33;
      rd(3'd4, 32'h77, "rx_pop_load");
      rx_val_i = 1'b0;
      rd(3'd2, 32'h06, "stat_no_ovr");
      rd(3'd4, 32'h33, "rx_new");
      rd(3'd4, 32'h33, "rx_stale");
      rd(3'd2, 32'h02, "stat_rx_empty");
      wr(3'd0, 32'h11);
      rx_val_i = 1'b1; rx_dat_i = 8'h99; tick();
      rx_val_i = 1'b0;
      rd(3'd2, 32'h02, "rx_disabled");
      rd(3'd5, 32'h6, "isr_rx");

      // Reset mid-burst
      wr(3'd0, 32'h71);
      wr(3'd3, 32'h01); wr(3'd3, 32'h02); wr(3'd3, 32'h03);
      rd(3'd0, 32'h71, "ctrl_pre_rst");
      chk("pre_rst_irq", 32'(irq_o), 1);
      chk("pre_rst_tx_val", 32'(tx_val_o), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_tx_val", 32'(tx_val_o), 0);
      chk("async_irq", 32'(irq_o), 0);
      chk("async_rd_dat", reg_rd_dat_o, 0);
      chk("async_tx_dat", 32'(tx_dat_o), 0);
      txq.delete();
      tick();
      rst = 1'b0;
      tick();
      rd(3'd2, 32'h2, "stat_post_rst");
      rd(3'd1, 32'h1B2, "baud_post_rst");
      rd(3'd5, 32'h0, "isr_post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
